// File: rtl/gtfmac_vnc_rx_frm_chk.sv
// gtfmac_vnc_rx_frm_chk: RX frame boundary tracker, length classifier and snapshotted statistics
module gtfmac_vnc_rx_frm_chk #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 48
) (
    input  logic             rx_axis_clk,
    input  logic             rx_axis_rstn,
    input  logic             din_ena,
    input  logic             din_sop,
    input  logic [63:0]      din_data,
    input  logic             din_eop,
    input  logic [2:0]       din_mty,
    input  logic             din_err,
    input  logic             din_empty,
    input  logic             stat_tick,
    output logic             frm_done,
    output logic [15:0]      frm_len,
    output logic             frm_good,
    output logic [CNT_W-1:0] stat_frames_good,
    output logic [CNT_W-1:0] stat_frames_bad,
    output logic [CNT_W-1:0] stat_runt,
    output logic [CNT_W-1:0] stat_oversize,
    output logic [CNT_W-1:0] stat_empty,
    output logic [CNT_W-1:0] stat_bytes,
    output logic [CNT_W-1:0] stat_proto_err,
    output logic             stat_valid
);
    typedef enum logic {IDLE, IN_FRAME} state_t;
    localparam logic [15:0] MIN16 = 16'(MIN_LEN);
    localparam logic [15:0] MAX16 = 16'(MAX_LEN);
    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d, len_d;
    logic             done_d, emp_d, proto_d, good_d, fr;
    logic [3:0]       last_b;
    logic [16:0]      sum;
    logic [CNT_W-1:0] cnt_q [7];
    logic [CNT_W-1:0] snap_q [7];
    logic [CNT_W-1:0] cnt_nx [7];
    logic [CNT_W-1:0] inc [7];
    logic             unused_data;
    assign unused_data = ^din_data;
    assign last_b = 4'd8 - {1'b0, din_mty};
    assign sum    = {1'b0, acc_q} + {13'd0, last_b};
    // Beat decode: a sop always starts a fresh frame; a sop inside a frame abandons it
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        len_d   = 16'd0;
        done_d  = 1'b0;
        emp_d   = 1'b0;
        proto_d = 1'b0;
        if (din_ena) begin
            if (din_sop) begin
                proto_d = (state_q == IN_FRAME);
                if (din_eop) begin
                    done_d  = 1'b1;
                    emp_d   = din_empty;
                    len_d   = din_empty ? 16'd0 : {12'd0, last_b};
                    state_d = IDLE;
                end else begin
                    acc_d   = 16'd8;
                    state_d = IN_FRAME;
                end
            end else if (state_q == IDLE) begin
                proto_d = 1'b1;
            end else if (din_eop) begin
                done_d  = 1'b1;
                len_d   = sum[16] ? 16'hFFFF : sum[15:0];
                state_d = IDLE;
            end else begin
                acc_d = (acc_q > 16'hFFF7) ? 16'hFFFF : acc_q + 16'd8;
            end
        end
    end
    assign fr     = done_d & ~emp_d;
    assign good_d = fr & ~din_err & (len_d >= MIN16) & (len_d <= MAX16);
    // Per-counter increments for this cycle's completion and protocol events
    always_comb begin
        inc[0] = CNT_W'(good_d);
        inc[1] = CNT_W'(fr & ~good_d);
        inc[2] = CNT_W'(fr & ~good_d & (len_d < MIN16));
        inc[3] = CNT_W'(fr & (len_d > MAX16));
        inc[4] = CNT_W'(emp_d);
        inc[5] = CNT_W'(fr ? len_d : 16'd0);
        inc[6] = CNT_W'(proto_d);
    end
    for (genvar i = 0; i < 7; i++) begin : g_sat
        logic [CNT_W:0] s;
        assign s         = {1'b0, cnt_q[i]} + {1'b0, inc[i]};
        assign cnt_nx[i] = s[CNT_W] ? '1 : s[CNT_W-1:0];
    end
    // State, completion record, live counters and tick snapshot
    always_ff @(posedge rx_axis_clk) begin
        if (!rx_axis_rstn) begin
            state_q    <= IDLE;
            acc_q      <= 16'd0;
            frm_done   <= 1'b0;
            frm_len    <= 16'd0;
            frm_good   <= 1'b0;
            stat_valid <= 1'b0;
            for (int k = 0; k < 7; k++) begin
                cnt_q[k]  <= '0;
                snap_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            frm_done   <= done_d;
            frm_len    <= len_d;
            frm_good   <= good_d;
            stat_valid <= stat_tick;
            for (int k = 0; k < 7; k++) begin
                cnt_q[k] <= stat_tick ? '0 : cnt_nx[k];
                if (stat_tick) snap_q[k] <= cnt_nx[k];
            end
        end
    end
    assign stat_frames_good = snap_q[0];
    assign stat_frames_bad  = snap_q[1];
    assign stat_runt        = snap_q[2];
    assign stat_oversize    = snap_q[3];
    assign stat_empty       = snap_q[4];
    assign stat_bytes       = snap_q[5];
    assign stat_proto_err   = snap_q[6];
endmodule

// File: tb/tb_gtfmac_vnc_rx_frm_chk.sv
// tb_gtfmac_vnc_rx_frm_chk: randomized frame traffic checked against a frame-level statistics model
module tb_gtfmac_vnc_rx_frm_chk;
    localparam int MINL = 64;
    localparam int MAXL = 1518;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        ena = 0, sop = 0, eop = 0, err = 0, emp = 0, tick = 0;
    logic [63:0] data = '0;
    logic [2:0]  mty = '0;
    logic        frm_done, frm_good, stat_valid;
    logic [15:0] frm_len;
    logic [47:0] s_good, s_bad, s_runt, s_over, s_empty, s_bytes, s_proto;
    int          total = 0, bad = 0;
    longint      m [7];
    string       names [7] = '{"good", "bad", "runt", "oversize", "empty", "bytes", "proto_err"};

    gtfmac_vnc_rx_frm_chk dut (
        .rx_axis_clk(clk), .rx_axis_rstn(rstn), .din_ena(ena), .din_sop(sop),
        .din_data(data), .din_eop(eop), .din_mty(mty), .din_err(err), .din_empty(emp),
        .stat_tick(tick), .frm_done(frm_done), .frm_len(frm_len), .frm_good(frm_good),
        .stat_frames_good(s_good), .stat_frames_bad(s_bad), .stat_runt(s_runt),
        .stat_oversize(s_over), .stat_empty(s_empty), .stat_bytes(s_bytes),
        .stat_proto_err(s_proto), .stat_valid(stat_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] stat(input int i);
        return 64'(i == 0 ? s_good : i == 1 ? s_bad : i == 2 ? s_runt : i == 3 ? s_over :
                   i == 4 ? s_empty : i == 5 ? s_bytes : s_proto);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, s, p, input logic [2:0] y, input logic r, z, t);
        ena = e; sop = s; eop = p; mty = y; err = r; emp = z; tick = t;
        data = {$urandom, $urandom};
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        step(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        chk("done_in_gap", 64'(frm_done), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            gap();
            chk("valid_idle", 64'(stat_valid), 64'd0);
        end
    endtask

    task automatic snap();
        chk("stat_valid", 64'(stat_valid), 64'd1);
        for (int i = 0; i < 7; i++) begin
            chk(names[i], stat(i), 64'(m[i]));
            m[i] = 0;
        end
    endtask

    task automatic tick_idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        snap();
    endtask

    task automatic send(input int len, input bit e, input bit tk);
        int          n = (len + 7) / 8;
        logic [2:0]  lm = 3'(n * 8 - len);
        int          l = len > 65535 ? 65535 : len;
        bit          g = !e && l >= MINL && l <= MAXL;
        for (int b = 0; b < n; b++) begin
            bit last = (b == n - 1);
            if (b > 0 && $urandom_range(0, 7) == 0) gap();
            step(1'b1, b == 0, last, last ? lm : 3'($urandom), last ? e : 1'($urandom), 1'b0, tk & last);
            if (!last) chk("done_mid", 64'(frm_done), 64'd0);
        end
        if (g) m[0]++;
        else begin
            m[1]++;
            if (l < MINL) m[2]++;
            if (l > MAXL) m[3]++;
        end
        m[5] += l;
        chk("frm_done", 64'(frm_done), 64'd1);
        chk("frm_len", 64'(frm_len), 64'(l));
        chk("frm_good", 64'(frm_good), 64'(g));
        if (tk) snap();
    endtask

    task automatic empty_beat();
        step(1'b1, 1'b1, 1'b1, 3'($urandom), 1'($urandom), 1'b1, 1'b0);
        m[4]++;
        chk("empty_done", 64'(frm_done), 64'd1);
        chk("empty_len", 64'(frm_len), 64'd0);
        chk("empty_good", 64'(frm_good), 64'd0);
    endtask

    task automatic stray();
        step(1'b1, 1'b0, 1'($urandom), 3'($urandom), 1'($urandom), 1'b0, 1'b0);
        m[6]++;
        chk("stray_done", 64'(frm_done), 64'd0);
    endtask

    task automatic partial(input int k);
        step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (k - 1) step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("partial_done", 64'(frm_done), 64'd0);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_done"}, 64'(frm_done), 64'd0);
        chk({tag, "_len"}, 64'(frm_len), 64'd0);
        chk({tag, "_good"}, 64'(frm_good), 64'd0);
        chk({tag, "_valid"}, 64'(stat_valid), 64'd0);
        for (int i = 0; i < 7; i++) chk({tag, "_", names[i]}, stat(i), 64'd0);
    endtask

    initial begin
        int bl [7] = '{63, 64, 1518, 1519, 1, 8, 9};
        for (int i = 0; i < 7; i++) m[i] = 0;
        step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        zero_chk("reset");
        rstn = 1'b1;
        send(64, 0, 0);
        tick_idle();
        send(60, 0, 0);
        send(1519, 0, 0);
        tick_idle();
        send(128, 1, 0);
        empty_beat();
        tick_idle();
        stray();
        partial(3);
        m[6]++;
        send(64, 0, 0);
        tick_idle();
        send(200, 0, 1);
        idle(4);
        tick_idle();
        partial(3);
        rstn = 1'b0;
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        zero_chk("midrst");
        for (int i = 0; i < 7; i++) m[i] = 0;
        rstn = 1'b1;
        send(64, 0, 0);
        tick_idle();
        foreach (bl[i]) send(bl[i], 0, 0);
        tick_idle();
        send(65576, 0, 0);
        tick_idle();
        for (int it = 0; it < 60; it++) begin
            int r = $urandom_range(0, 9);
            int sel = $urandom_range(0, 3);
            int len = sel == 0 ? $urandom_range(1, 80) : sel == 1 ? $urandom_range(56, 72) :
                      sel == 2 ? $urandom_range(1500, 1530) : $urandom_range(1, 1600);
            if (r == 0) empty_beat();
            else if (r == 1) stray();
            else if (r == 2) tick_idle();
            else if (r == 3) begin
                partial($urandom_range(1, 4));
                m[6]++;
                send(len, $urandom_range(0, 7) == 0, 0);
            end else send(len, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) gap();
        end
        tick_idle();
        tick_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gtfmac_vnc_rx_frm_chk.md
Name: gtfmac_vnc_rx_frm_chk

Overview:
- Frame checker and statistics stage directly downstream of the RX GTFMAC interface adapter.
- Consumes the adapter's 64-bit beat stream (ena/sop/data/eop/mty/err/empty) and tracks frame boundaries.
- Computes per-frame byte length, classifies each frame, and keeps saturating statistics counters that are snapshotted on a tick.
- Emits a one-cycle per-frame completion record for the latency and monitor logic.

Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes; shorter non-empty frames are runts.
- MAX_LEN, 1518: maximum legal frame length in bytes; longer frames are oversize.
- CNT_W, 48: width of every statistics counter.

Ports:
- rx_axis_clk  in  1  sole clock.
- rx_axis_rstn  in  1  synchronous active-low reset. Design has one clock; reset is synchronous and active-low.
- din_ena  in  1  beat valid; all other din_* inputs are ignored when 0.
- din_sop  in  1  first beat of a frame.
- din_data  in  64  beat data (not inspected; present for future payload checks).
- din_eop  in  1  last beat of a frame.
- din_mty  in  3  empty bytes on the eop beat (0 = 8 valid bytes).
- din_err  in  1  frame error flag, sampled on the eop beat.
- din_empty  in  1  zero-length frame marker (arrives with sop=eop=1).
- stat_tick  in  1  snapshot-and-clear strobe.
- frm_done  out  1  one-cycle pulse, one frame completed.
- frm_len  out  16  byte length of the completed frame (saturates at 16'hFFFF).
- frm_good  out  1  completed frame is good: no err, MIN_LEN <= len <= MAX_LEN.
- stat_frames_good, stat_frames_bad, stat_runt, stat_oversize, stat_empty, stat_bytes, stat_proto_err  out  CNT_W each  snapshotted counters.
- stat_valid  out  1  one-cycle pulse, one cycle after stat_tick, when the snapshot outputs update.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - FSM goes to IDLE; byte accumulator and all live counters clear.
  - frm_done, frm_len, frm_good, stat_valid and all stat_* outputs go to 0.
  - A frame that was in progress is discarded and not counted.
- FSM has two states, IDLE and IN_FRAME. A beat is any cycle with din_ena=1.
- In IDLE:
  - sop & eop & empty: frame complete with len 0. Increment stat_empty only. frm_done=1, frm_good=0. Stay in IDLE.
  - sop & eop (not empty): single-beat frame, len = 8 - mty. Complete the frame. Stay in IDLE.
  - sop, no eop: acc = 8. Go to IN_FRAME.
  - No sop: protocol error. stat_proto_err +1; beat dropped.
- In IN_FRAME:
  - No sop, no eop: acc += 8, saturating at 16'hFFFF.
  - No sop, eop: len = acc + 8 - mty, saturating. Complete the frame. Go to IDLE.
  - sop: protocol error. stat_proto_err +1; the current frame is abandoned and not counted. The new beat is handled exactly as in IDLE, in the same cycle.
- Frame completion:
  - frm_done, frm_len and frm_good are registered and appear 1 cycle after the eop beat.
  - bad = err | len < MIN_LEN | len > MAX_LEN.
  - Good frame: stat_frames_good +1 and stat_bytes += len.
  - Bad frame: stat_frames_bad +1 and stat_bytes += len. Additionally stat_runt +1 if 0 < len < MIN_LEN, and stat_oversize +1 if len > MAX_LEN.
  - Counter updates land on the same edge as frm_done.
- Counters:
  - All counters are unsigned and saturate at 2^CNT_W - 1; no wrap.
  - stat_bytes saturates when the addition would overflow.
- stat_tick:
  - On the edge after stat_tick, each stat_* output receives its live counter value including any increment from that same cycle's completion.
  - On that same edge the live counters restart from 0.
  - stat_valid pulses on that same edge.
  - Back-to-back ticks produce an all-zero second snapshot when no events occur between them.
- Throughput is one beat per cycle with no backpressure; the block never stalls.

Test Plan:
- 64-byte frame (8 beats, last mty=0, err=0), then tick → frm_done 1 cycle after eop; frm_len=64, frm_good=1; stat_frames_good=1, stat_bytes=64, all others 0, stat_valid=1.
- 60-byte frame (last mty=4) followed by 1519-byte frame (190 beats, last mty=1) → frm_len=60 then 1519; stat_runt=1, stat_oversize=1, stat_frames_bad=2, stat_bytes=1579.
- 128-byte frame with err=1 on eop; a separate beat with sop=eop=empty=1 → bad=1, runt=0, oversize=0; stat_empty=1 with frm_len=0; stat_bytes=128.
- Beat without sop while IDLE; then sop mid-frame followed by a valid 64-byte frame → stat_proto_err=2; only the 64-byte frame is counted as good.
- stat_tick asserted in the same cycle as an eop beat, then tick again 5 cycles later with no traffic → first snapshot includes the frame; second snapshot is all zeros.
- rstn=0 for 1 cycle mid-frame, then a clean 64-byte frame → aborted frame not counted; good=1, proto_err=0.
